// File: rtl/rv32im_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// rv32im_muldiv_pkg
//   Shared definitions for the RV32M multiply/divide unit: funct3 operation
//   codes, FSM state encodings and small decode helpers used on request
//   capture.
// ---------------------------------------------------------------------------
package rv32im_muldiv_pkg;

  localparam int MULDIV_OP_WIDTH = 3;

  // RISC-V funct3 encodings for the M extension
  typedef enum logic [MULDIV_OP_WIDTH-1:0] {
    MULDIV_OP_MUL    = 3'b000,
    MULDIV_OP_MULH   = 3'b001,
    MULDIV_OP_MULHSU = 3'b010,
    MULDIV_OP_MULHU  = 3'b011,
    MULDIV_OP_DIV    = 3'b100,
    MULDIV_OP_DIVU   = 3'b101,
    MULDIV_OP_REM    = 3'b110,
    MULDIV_OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'b00,
    MULDIV_ST_CALC = 2'b01,
    MULDIV_ST_DONE = 2'b10
  } muldiv_state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input muldiv_op_e op);
    logic [MULDIV_OP_WIDTH-1:0] code;
    code = op;
    return code[2];
  endfunction

  // Within the divide family funct3[1] selects the remainder
  function automatic logic op_is_rem(input muldiv_op_e op);
    logic [MULDIV_OP_WIDTH-1:0] code;
    code = op;
    return code[2] & code[1];
  endfunction

  function automatic logic op1_is_signed(input muldiv_op_e op);
    return (op == MULDIV_OP_MUL)    || (op == MULDIV_OP_MULH) ||
           (op == MULDIV_OP_MULHSU) || (op == MULDIV_OP_DIV)  ||
           (op == MULDIV_OP_REM);
  endfunction

  function automatic logic op2_is_signed(input muldiv_op_e op);
    return (op == MULDIV_OP_MUL) || (op == MULDIV_OP_MULH) ||
           (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
  endfunction

endpackage

// File: rtl/rv32im_muldiv_negate.sv
// ---------------------------------------------------------------------------
// rv32im_muldiv_negate
//   Combinational conditional two's-complement. Used to take absolute values
//   of operands on capture and to restore the sign of results.
//   Ports:
//     neg      in  1      negate when high, pass through when low
//     data_in  in  WIDTH  value
//     data_out out WIDTH  neg ? -data_in : data_in (modulo 2^WIDTH)
// ---------------------------------------------------------------------------
module rv32im_muldiv_negate
  import rv32im_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Wraps modulo 2^WIDTH, so the most negative value maps onto itself
  assign data_out = neg ? (~data_in + WIDTH'(1)) : data_in;

endmodule

// File: rtl/rv32im_muldiv.sv
// ---------------------------------------------------------------------------
// rv32im_muldiv
//   Multi-cycle RV32M execution unit: radix-2 shift-add multiply and
//   restoring shift-subtract divide on operand magnitudes, with the sign
//   applied on the final iteration. Division by zero and signed overflow
//   bypass the iteration and respond the cycle after the accept.
//   Ports:
//     clk_i         in  1           rising-edge clock
//     rst_ni        in  1           asynchronous active-low reset
//     req_valid_i   in  1           request present
//     req_ready_o   out 1           unit idle, can accept a request
//     req_op_i      in  3           funct3 (MUL..REMU)
//     req_op1_i     in  DATA_WIDTH  rs1 value
//     req_op2_i     in  DATA_WIDTH  rs2 value
//     flush_i       in  1           abort any in-flight operation
//     resp_valid_o  out 1           result available
//     resp_ready_i  in  1           consumer takes result
//     resp_data_o   out DATA_WIDTH  result
//     busy_o        out 1           unit not idle
// ---------------------------------------------------------------------------
module rv32im_muldiv
  import rv32im_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [MULDIV_OP_WIDTH-1:0] req_op_i,
  input  logic [DATA_WIDTH-1:0]      req_op1_i,
  input  logic [DATA_WIDTH-1:0]      req_op2_i,
  input  logic                       flush_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [DATA_WIDTH-1:0]      resp_data_o,
  output logic                       busy_o
);

  localparam int                   W        = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [W-1:0]         INT_MIN  = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e       state;
  logic [CNT_WIDTH-1:0] cnt;
  muldiv_op_e          op_q;
  logic [W-1:0]        mcand_q;   // |op2|: multiplicand or divisor
  logic [2*W-1:0]      acc_q;     // mul: {high, multiplier}, div: {rem, quo}
  logic                sgn_q;     // product / quotient sign
  logic                rsgn_q;    // remainder sign
  logic [W-1:0]        resp_data_q;

  // ---------------------------------------------------------------------
  // Request decode and operand magnitudes
  // ---------------------------------------------------------------------
  muldiv_op_e          req_op;
  logic signed [W-1:0] op1_s;
  logic signed [W-1:0] op2_s;
  logic                s1;
  logic                s2;
  logic [W-1:0]        abs1;
  logic [W-1:0]        abs2;
  logic                accept;
  logic                div_zero;
  logic                div_ovf;
  logic [W-1:0]        fast_data;

  assign req_op = muldiv_op_e'(req_op_i);
  assign op1_s  = req_op1_i;
  assign op2_s  = req_op2_i;
  assign s1     = op1_is_signed(req_op) && (op1_s < 0);
  assign s2     = op2_is_signed(req_op) && (op2_s < 0);

  assign req_ready_o  = (state == MULDIV_ST_IDLE);
  assign resp_valid_o = (state == MULDIV_ST_DONE);
  assign busy_o       = (state != MULDIV_ST_IDLE);
  assign resp_data_o  = resp_data_q;

  assign accept = req_valid_i & req_ready_o & ~flush_i;

  rv32im_muldiv_negate #(.WIDTH(W)) u_neg_op1 (
    .neg      (s1),
    .data_in  (req_op1_i),
    .data_out (abs1)
  );

  rv32im_muldiv_negate #(.WIDTH(W)) u_neg_op2 (
    .neg      (s2),
    .data_in  (req_op2_i),
    .data_out (abs2)
  );

  // Cases the iterative divider cannot produce with ISA-correct results
  assign div_zero = op_is_div(req_op) && (req_op2_i == '0);
  assign div_ovf  = ((req_op == MULDIV_OP_DIV) || (req_op == MULDIV_OP_REM)) &&
                    (req_op1_i == INT_MIN) && (req_op2_i == '1);

  always_comb begin
    fast_data = '0;
    if (div_zero) begin
      fast_data = op_is_rem(req_op) ? req_op1_i : '1;
    end else if (div_ovf) begin
      fast_data = op_is_rem(req_op) ? '0 : INT_MIN;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step for each datapath
  // ---------------------------------------------------------------------
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  // Add the multiplicand when the current multiplier bit is set, then shift
  // the {carry, high, multiplier} word right by one.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; a borrow in bit W means the divisor did not fit.
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_ge    = ~div_diff[W];
  assign div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]),
                      acc_q[W-2:0], div_ge};

  // ---------------------------------------------------------------------
  // Sign correction of the final iteration's result
  // ---------------------------------------------------------------------
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [W-1:0]   result;

  rv32im_muldiv_negate #(.WIDTH(2*W)) u_neg_prod (
    .neg      (sgn_q),
    .data_in  (mul_next),
    .data_out (prod_fix)
  );

  rv32im_muldiv_negate #(.WIDTH(W)) u_neg_quo (
    .neg      (sgn_q),
    .data_in  (div_next[W-1:0]),
    .data_out (quo_fix)
  );

  rv32im_muldiv_negate #(.WIDTH(W)) u_neg_rem (
    .neg      (rsgn_q),
    .data_in  (div_next[2*W-1:W]),
    .data_out (rem_fix)
  );

  always_comb begin
    result = '0;
    case (op_q)
      MULDIV_OP_MUL:                     result = prod_fix[W-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU,
      MULDIV_OP_MULHU:                   result = prod_fix[2*W-1:W];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:     result = quo_fix;
      MULDIV_OP_REM, MULDIV_OP_REMU:     result = rem_fix;
      default:                           result = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= MULDIV_ST_IDLE;
      cnt         <= '0;
      op_q        <= MULDIV_OP_MUL;
      mcand_q     <= '0;
      acc_q       <= '0;
      sgn_q       <= 1'b0;
      rsgn_q      <= 1'b0;
      resp_data_q <= '0;
    end else if (flush_i) begin
      // Abort wins over accept and over the response handshake
      state <= MULDIV_ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MULDIV_ST_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            mcand_q <= abs2;
            acc_q   <= {{W{1'b0}}, abs1};
            sgn_q   <= s1 ^ s2;
            rsgn_q  <= s1;
            cnt     <= CNT_LAST;
            if (div_zero || div_ovf) begin
              state       <= MULDIV_ST_DONE;
              resp_data_q <= fast_data;
            end else begin
              state <= MULDIV_ST_CALC;
            end
          end
        end

        MULDIV_ST_CALC: begin
          acc_q <= op_is_div(op_q) ? div_next : mul_next;
          if (cnt == '0) begin
            state       <= MULDIV_ST_DONE;
            resp_data_q <= result;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        MULDIV_ST_DONE: begin
          if (resp_ready_i) begin
            state <= MULDIV_ST_IDLE;
          end
        end

        default: state <= MULDIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_muldiv.sv
// ---------------------------------------------------------------------------
// tb_rv32im_muldiv
//   Scoreboard bench for rv32im_muldiv: stimulus pushes the hand-computed
//   result and expected latency for every request it issues; a monitor
//   compares data (and stability under backpressure) whenever the unit
//   presents a response.
// ---------------------------------------------------------------------------
module tb_rv32im_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        busy;

  rv32im_muldiv #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_op1_i    (op1),
    .req_op2_i    (op2),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_resp = 1'b0;
  int   first_cyc = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request; when track is set, the expected response is queued.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit track = 1'b1);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: req_ready still 0 after %0d cycles, expected 1", name, n);
    end
    req_valid = 1'b1;
    req_op    = op;
    op1       = a;
    op2       = b;
    @(posedge clk); #1;
    if (track) sb.push_back('{name: name, data: exp, lat: lat, acc_cyc: cyc});
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d responses outstanding, busy=%0b, expected 0 and 0",
               name, sb.size(), busy);
      sb.delete();
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !resp_valid) begin
        in_resp = 1'b0;
      end else begin
        if (!in_resp) begin
          in_resp   = 1'b1;
          first_cyc = cyc;
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got response 0x%08h, expected none", resp_data);
        end else if (!resp_ready) begin
          check32({sb[0].name, "_stall_data"}, resp_data, sb[0].data);
        end else begin
          e = sb.pop_front();
          check32(e.name, resp_data, e.data);
          check32({e.name, "_latency"}, 32'(first_cyc - e.acc_cyc + 1), 32'(e.lat));
          in_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_hi;
    int n;

    // Reset values
    #12;
    check32("rst_req_ready",  32'(req_ready),  32'd1);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_resp_data",  resp_data,       32'h0);
    check32("rst_busy",       32'(busy),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic multiply with req_ready held low while computing
    issue("mul_basic", MUL, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 33);
    ready_hi = 0;
    n = 0;
    while (!resp_valid && n < 60) begin
      if (req_ready) ready_hi++;
      @(posedge clk); #1;
      n++;
    end
    check32("mul_req_ready_low_cycles", 32'(ready_hi), 32'd0);
    wait_done("mul_basic");

    // High-half and other multiply patterns
    issue("mulh_m1_m1",    MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    issue("mulhu_max",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    issue("mulhsu_m1_max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    issue("mul_m1_m1",     MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    issue("mulh_min_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    issue("mulhu_min_x4",  MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
    wait_done("mul_group");

    // Division, normal path
    issue("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
    issue("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    issue("divu_100_7", DIVU, 32'd100,       32'd7,         32'd14,        33);
    issue("remu_100_7", REMU, 32'd100,       32'd7,         32'd2,         33);
    issue("div_m7_m2",  DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 33);
    issue("rem_m7_m2",  REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    issue("divu_min_max", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    wait_done("div_group");

    // Fast paths: divide by zero and signed overflow
    issue("div_by_zero",  DIV,  32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    issue("rem_by_zero",  REM,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
    issue("divu_by_zero", DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    issue("remu_by_zero", REMU, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1);
    issue("div_ovf",      DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem_ovf",      REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    wait_done("fast_group");

    // Backpressure: hold the response for 10 cycles
    resp_ready = 1'b0;
    issue("mul_bp", MUL, 32'd7, 32'd6, 32'd42, 33);
    n = 0;
    while (!resp_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check32("bp_valid_seen", 32'(resp_valid), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check32("bp_valid_held",    32'(resp_valid), 32'd1);
    check32("bp_ready_in_done", 32'(req_ready),  32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check32("bp_ready_after_hs", 32'(req_ready),  32'd1);
    check32("bp_valid_after_hs", 32'(resp_valid), 32'd0);
    wait_done("backpressure");

    // Flush during CALC; the aborted op must not respond
    issue("flush_victim", DIVU, 32'hFFFF_FFFF, 32'd3, 32'h0, 33, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check32("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check32("flush_busy_after",  32'(busy),       32'd0);
    check32("flush_ready_after", 32'(req_ready),  32'd1);
    check32("flush_valid_after", 32'(resp_valid), 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    issue("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33);
    wait_done("after_flush");

    // Asynchronous reset in the middle of CALC
    issue("rst_victim", MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 33, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    check32("rst_mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("rst_mid_req_ready",  32'(req_ready),  32'd1);
    check32("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_mid_resp_data",  resp_data,       32'h0);
    check32("rst_mid_busy",       32'(busy),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue("mulhu_after_rst", MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
    wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
